corefifo_wr_ptr_gray_gen: RTL and testbench
===========================================

Name: corefifo_wr_ptr_gray_gen

Overview:
- Write-side pointer generator for the async FIFO: the encoding end of the pointer clock-domain crossing.
- Keeps a binary write pointer and publishes it as a registered Gray-code pointer for the read domain.
- Takes the already-synchronised read Gray pointer, decodes it internally to binary, and derives registered full, almost-full, fill count and overflow flags in the write clock domain.

Parameters:
- ADDRWIDTH, 3, address bits. FIFO depth = 2^ADDRWIDTH. Pointers are ADDRWIDTH+1 bits wide. Must be >= 2.
- AFULL_VAL, 6, afull asserts when fill count >= AFULL_VAL. Legal range 1..2^ADDRWIDTH.

Ports:
- clk  in  1  write-domain clock; all state updates on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- we  in  1  write request from the user.
- rd_gray_sync  in  ADDRWIDTH+1  read pointer in Gray code, already synchronised into clk.
- wr_en_mem  out  1  RAM write enable, combinational: we & ~full.
- wr_addr  out  ADDRWIDTH  RAM write address: wr_bin[ADDRWIDTH-1:0].
- wr_bin  out  ADDRWIDTH+1  registered binary write pointer.
- wr_gray  out  ADDRWIDTH+1  registered Gray write pointer, sent to the read-domain synchroniser.
- full  out  1  registered full flag.
- afull  out  1  registered almost-full flag.
- wr_cnt  out  ADDRWIDTH+1  registered fill level, 0..2^ADDRWIDTH.
- overflow  out  1  registered one-cycle pulse for a write attempted while full.

Behaviour:
- Reset: when rstn=0 at a clk edge, wr_bin, wr_gray, full, afull, wr_cnt and overflow all clear to 0. This holds even with we=1 or mid-sequence. No write is accepted in that cycle.
- Next binary pointer: bin_nxt = wr_bin + wr_en_mem, modulo 2^(ADDRWIDTH+1). It wraps naturally; there is no saturation.
- Next Gray pointer: gray_nxt = bin_nxt ^ (bin_nxt >> 1). Registered into wr_gray. Successive wr_gray values differ in exactly one bit, including at wrap.
- Read pointer decode: rd_bin = combinational Gray-to-binary of rd_gray_sync.
  - MSB is copied directly.
  - For each lower bit i: rd_bin[i] = rd_bin[i+1] ^ rd_gray_sync[i].
- Full: full_nxt = (gray_nxt == {~rd_gray_sync[ADDRWIDTH:ADDRWIDTH-1], rd_gray_sync[ADDRWIDTH-2:0]}).
  - full asserts on the same edge as the write that fills the FIFO.
  - full deasserts on the first edge after rd_gray_sync advances.
- Fill count: wr_cnt_nxt = bin_nxt - rd_bin, modulo 2^(ADDRWIDTH+1). Registered.
- Almost-full: afull_nxt = (wr_cnt_nxt >= AFULL_VAL). Registered.
- Overflow: overflow_nxt = we & full. The pointer does not move in that cycle.
- Simultaneous write and read-pointer advance in one cycle: both are applied. wr_cnt stays unchanged and full is recomputed from both new values.
- Latency: wr_en_mem is 0-cycle combinational. All other outputs are registered, with 1-cycle latency from we / rd_gray_sync.
- rd_gray_sync is trusted as a valid Gray value. No checking is done on it.
- No other state and no FSM beyond the pointer and flag registers.

Test Plan (ADDRWIDTH=3, AFULL_VAL=6):
1. Reset, then hold we=1 with rd_gray_sync=0 for 8 cycles -> wr_gray steps 1,3,2,6,7,5,4,C; afull=1 after the 6th edge; full=1 and wr_cnt=8 after the 8th edge.
2. From full, keep we=1 for 2 more cycles -> wr_en_mem=0, wr_bin stays 8, overflow=1 for both cycles, wr_cnt stays 8.
3. From full, set rd_gray_sync=0x1 (rd_bin=1) with we=0 -> full=0, wr_cnt=7, afull=1 on the next edge; wr_en_mem=1 as soon as we rises.
4. Wrap-around: track rd_gray_sync one write behind for 20 writes -> wr_bin goes 15->0, wr_gray goes 0x8->0x0, full never asserts, wr_cnt=1 throughout.
5. Simultaneous event: at wr_cnt=4, apply we=1 and advance rd_gray_sync by one in the same cycle -> wr_cnt=4, wr_bin+1, no flag change.
6. Reset mid-operation: drive rstn=0 at wr_bin=5 with we=1 -> after the edge all outputs are 0, and the first write after release produces wr_gray=1.

Source files
------------

// File: rtl/corefifo_wr_ptr_gray_gen.sv
// Write-side pointer generator for the async FIFO: binary/Gray write pointer plus full, afull, fill count and overflow.
// Latency: wr_en_mem is combinational from we/full; every other output is registered one cycle after we / rd_gray_sync.
// Backpressure: full blocks the write (wr_en_mem low, pointer held) and a write attempted while full pulses overflow.
module corefifo_wr_ptr_gray_gen #(
   parameter int ADDRWIDTH = 3,
   parameter int AFULL_VAL = 6
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 we,
   input  logic [ADDRWIDTH:0]   rd_gray_sync,
   output logic                 wr_en_mem,
   output logic [ADDRWIDTH-1:0] wr_addr,
   output logic [ADDRWIDTH:0]   wr_bin,
   output logic [ADDRWIDTH:0]   wr_gray,
   output logic                 full,
   output logic                 afull,
   output logic [ADDRWIDTH:0]   wr_cnt,
   output logic                 overflow
);

   // Pointers carry one extra wrap bit above the RAM address.
   localparam int PW = ADDRWIDTH + 1;

   // Threshold held at pointer width; the fill count never exceeds 2^ADDRWIDTH, so it fits.
   localparam logic [ADDRWIDTH:0] AFULL_THR = PW'(AFULL_VAL);

   logic [ADDRWIDTH:0] bin_nxt;
   logic [ADDRWIDTH:0] gray_nxt;
   logic [ADDRWIDTH:0] rd_bin;
   logic [ADDRWIDTH:0] rd_gray_full;
   logic [ADDRWIDTH:0] wr_cnt_nxt;
   logic               full_nxt;
   logic               afull_nxt;
   logic               overflow_nxt;

   // The RAM write is gated only by the registered full flag, so it never
   // waits on the pointer update it causes.
   assign wr_en_mem = we & ~full;
   assign wr_addr   = wr_bin[ADDRWIDTH-1:0];

   // Decode the synchronised read Gray pointer back to binary, MSB downwards.
   always_comb begin
      rd_bin            = '0;
      rd_bin[ADDRWIDTH] = rd_gray_sync[ADDRWIDTH];
      for (int i = ADDRWIDTH - 1; i >= 0; i--) begin
         rd_bin[i] = rd_bin[i+1] ^ rd_gray_sync[i];
      end
   end

   // Next-state pointers and flags, all computed from the post-write pointer
   // so the flags line up with the edge that moves the pointer.
   always_comb begin
      bin_nxt      = wr_bin + {{ADDRWIDTH{1'b0}}, wr_en_mem};
      gray_nxt     = bin_nxt ^ (bin_nxt >> 1);
      // In Gray code, "one full lap ahead" means the top two bits inverted
      // and the remaining bits equal.
      rd_gray_full = {~rd_gray_sync[ADDRWIDTH:ADDRWIDTH-1], rd_gray_sync[ADDRWIDTH-2:0]};
      full_nxt     = (gray_nxt == rd_gray_full);
      wr_cnt_nxt   = bin_nxt - rd_bin;
      afull_nxt    = (wr_cnt_nxt >= AFULL_THR);
      overflow_nxt = we & full;
   end

   // Pointer and flag registers; synchronous reset wins over any write in the same cycle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_bin   <= '0;
         wr_gray  <= '0;
         full     <= 1'b0;
         afull    <= 1'b0;
         wr_cnt   <= '0;
         overflow <= 1'b0;
      end else begin
         wr_bin   <= bin_nxt;
         wr_gray  <= gray_nxt;
         full     <= full_nxt;
         afull    <= afull_nxt;
         wr_cnt   <= wr_cnt_nxt;
         overflow <= overflow_nxt;
      end
   end

endmodule

// File: tb/tb_corefifo_wr_ptr_gray_gen.sv
// Directed bench for corefifo_wr_ptr_gray_gen at ADDRWIDTH=3, AFULL_VAL=6.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
// Expected values come from hand-written tables and bench-side pointer tracking.
module tb_corefifo_wr_ptr_gray_gen;

   logic       clk;
   logic       rstn;
   logic       we;
   logic [3:0] rd_gray_sync;
   logic       wr_en_mem;
   logic [2:0] wr_addr;
   logic [3:0] wr_bin;
   logic [3:0] wr_gray;
   logic       full;
   logic       afull;
   logic [3:0] wr_cnt;
   logic       overflow;

   int n_cmp = 0;
   int n_err = 0;

   // Gray code of 0..15, written out by hand.
   logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   corefifo_wr_ptr_gray_gen #(.ADDRWIDTH(3), .AFULL_VAL(6)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .we           (we),
      .rd_gray_sync (rd_gray_sync),
      .wr_en_mem    (wr_en_mem),
      .wr_addr      (wr_addr),
      .wr_bin       (wr_bin),
      .wr_gray      (wr_gray),
      .full         (full),
      .afull        (afull),
      .wr_cnt       (wr_cnt),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] exp_bin;
      logic [3:0] prev_gray;

      // Reset with the write request low.
      rstn = 1'b0; we = 1'b0; rd_gray_sync = 4'h0;
      tick(); tick();
      chk("rst_bin", wr_bin, 0);
      chk("rst_gray", wr_gray, 0);
      chk("rst_full", full, 0);
      chk("rst_afull", afull, 0);
      chk("rst_cnt", wr_cnt, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_wen", wr_en_mem, 0);

      // 1. Fill from empty with the read pointer parked at 0.
      rstn = 1'b1; we = 1'b1;
      #1 chk("fill_wen0", wr_en_mem, 1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("fill_gray%0d", i), wr_gray, gtab[i]);
         chk($sformatf("fill_bin%0d", i), wr_bin, i);
         chk($sformatf("fill_addr%0d", i), wr_addr, i % 8);
         chk($sformatf("fill_cnt%0d", i), wr_cnt, i);
         chk($sformatf("fill_afull%0d", i), afull, (i >= 6) ? 1 : 0);
         chk($sformatf("fill_full%0d", i), full, (i == 8) ? 1 : 0);
      end

      // 2. Keep writing while full: RAM write blocked, overflow pulses.
      chk("ovf_wen", wr_en_mem, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("ovf_bin", wr_bin, 8);
         chk("ovf_flag", overflow, 1);
         chk("ovf_cnt", wr_cnt, 8);
         chk("ovf_full", full, 1);
      end
      we = 1'b0;
      tick();
      chk("ovf_clear", overflow, 0);

      // 3. Read pointer advances by one while full.
      rd_gray_sync = 4'h1;
      tick();
      chk("drain_full", full, 0);
      chk("drain_cnt", wr_cnt, 7);
      chk("drain_afull", afull, 1);
      we = 1'b1;
      #1 chk("drain_wen", wr_en_mem, 1);
      we = 1'b0;
      #1 chk("drain_wen_off", wr_en_mem, 0);

      // 4. Read pointer to 7 (Gray 4) leaves one entry, then track one write behind across the wrap.
      rd_gray_sync = 4'h4;
      tick();
      chk("wrap_pre_cnt", wr_cnt, 1);
      chk("wrap_pre_afull", afull, 0);
      exp_bin = 4'd8;
      prev_gray = 4'hC;
      for (int k = 0; k < 20; k++) begin
         rd_gray_sync = gtab[exp_bin];
         we = 1'b1;
         tick();
         exp_bin = exp_bin + 4'd1;
         chk("wrap_bin", wr_bin, exp_bin);
         chk("wrap_gray", wr_gray, gtab[exp_bin]);
         chk("wrap_cnt", wr_cnt, 1);
         chk("wrap_full", full, 0);
         chk("wrap_onebit", $countones(wr_gray ^ prev_gray), 1);
         if (exp_bin == 4'd0) chk("wrap_gray_zero", wr_gray, 4'h0);
         prev_gray = wr_gray;
      end
      // Pointer is now 12, read at 11.

      // 5. Three more writes with the read pointer fixed reach a count of 4.
      for (int k = 0; k < 3; k++) tick();
      chk("sim_pre_bin", wr_bin, 15);
      chk("sim_pre_cnt", wr_cnt, 4);
      chk("sim_pre_gray", wr_gray, 4'h8);
      rd_gray_sync = gtab[12];
      tick();
      chk("sim_bin", wr_bin, 0);
      chk("sim_gray", wr_gray, 4'h0);
      chk("sim_cnt", wr_cnt, 4);
      chk("sim_full", full, 0);
      chk("sim_afull", afull, 0);

      // 6. Advance to pointer 5 with the read side one behind, then reset mid-write.
      exp_bin = 4'd0;
      for (int k = 0; k < 5; k++) begin
         rd_gray_sync = gtab[exp_bin];
         tick();
         exp_bin = exp_bin + 4'd1;
      end
      chk("mid_bin", wr_bin, 5);
      chk("mid_cnt", wr_cnt, 1);
      rstn = 1'b0;
      tick();
      chk("mrst_bin", wr_bin, 0);
      chk("mrst_gray", wr_gray, 0);
      chk("mrst_full", full, 0);
      chk("mrst_afull", afull, 0);
      chk("mrst_cnt", wr_cnt, 0);
      chk("mrst_ovf", overflow, 0);
      rstn = 1'b1;
      rd_gray_sync = 4'h0;
      tick();
      chk("post_gray", wr_gray, 4'h1);
      chk("post_bin", wr_bin, 1);
      chk("post_cnt", wr_cnt, 1);
      we = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
